// File: rtl/eth_frame_gen.sv
// Ethernet test-frame transmitter: fixed-length frames with a MAC/EtherType header,
// a 32-bit sequence number and an index-derived payload, sent on a 64-bit AXI-Stream master.
module eth_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk156,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] frame_len,
  input  logic [15:0] frame_cnt,
  input  logic [7:0]  gap,
  output logic        busy,
  output logic [31:0] sent_cnt,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        tx_tuser
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  last_beat_q, last_beat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  gap_ctr_q, gap_ctr_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] sent_q, sent_d;
  logic        stop_req_q, stop_req_d;
  logic        busy_q, busy_d;
  logic        tvalid_q, tvalid_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_d, tkeep_q;
  logic        tlast_q, tlast_d;

  logic        load;
  logic [7:0]  ld_beat;
  logic [31:0] ld_seq;
  logic [10:0] ld_len;
  logic [7:0]  ld_last;
  logic [10:0] start_len;
  logic [31:0] sent_inc;
  logic        run_done;

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    if (l < 11'd60)        return 11'd60;
    else if (l > 11'd1514) return 11'd1514;
    else                   return l;
  endfunction

  function automatic logic [7:0] last_beat_of(input logic [10:0] l);
    logic [10:0] t;
    t = l + 11'd7;
    return t[10:3] - 8'd1;
  endfunction

  function automatic logic [7:0] last_keep_of(input logic [10:0] l);
    if (l[2:0] == 3'd0) return 8'hFF;
    else                return (8'h01 << l[2:0]) - 8'h01;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [10:0] i, input logic [31:0] seq);
    logic [111:0] hdr;
    logic [31:0]  s;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE} << {i[3:0], 3'b000};
    s   = seq << {i[1:0] + 2'd2, 3'b000};
    if (i < 11'd14)      return hdr[111:104];
    else if (i < 11'd18) return s[31:24];
    else                 return i[7:0];
  endfunction

  // Lanes past the end of the frame are driven as zero.
  function automatic logic [63:0] beat_data(input logic [7:0] b, input logic [31:0] seq,
                                            input logic [10:0] l);
    logic [63:0] d;
    logic [10:0] idx;
    d = '0;
    for (int n = 0; n < 8; n++) begin
      idx = {b, 3'(n)};
      d[8*n +: 8] = (idx < l) ? frame_byte(idx, seq) : 8'h00;
    end
    return d;
  endfunction

  assign start_len = clamp_len(frame_len);
  assign sent_inc  = sent_q + 32'd1;
  assign run_done  = ((cnt_q != 16'd0) && (sent_inc == {16'd0, cnt_q})) || stop_req_q || stop;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    last_beat_d = last_beat_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    gap_ctr_d   = gap_ctr_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    sent_d      = sent_q;
    stop_req_d  = stop_req_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    load        = 1'b0;
    ld_beat     = beat_q + 8'd1;
    ld_seq      = seq_q;
    ld_len      = len_q;

    case (state_q)
      IDLE: begin
        tvalid_d   = 1'b0;
        tdata_d    = '0;
        tkeep_d    = '0;
        tlast_d    = 1'b0;
        stop_req_d = 1'b0;
        if (start) begin
          len_d       = start_len;
          last_beat_d = last_beat_of(start_len);
          cnt_d       = frame_cnt;
          gap_d       = gap;
          sent_d      = '0;
          seq_d       = '0;
          stop_req_d  = stop;
          state_d     = SEND;
          load        = 1'b1;
          ld_beat     = 8'd0;
          ld_seq      = '0;
          ld_len      = start_len;
        end
      end
      SEND: begin
        if (stop) stop_req_d = 1'b1;
        if (tvalid_q && tx_tready) begin
          if (tlast_q) begin
            sent_d = sent_inc;
            seq_d  = seq_q + 32'd1;
            if (run_done) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tdata_d  = '0;
              tkeep_d  = '0;
              tlast_d  = 1'b0;
            end else if (gap_q == 8'd0) begin
              load    = 1'b1;
              ld_beat = 8'd0;
              ld_seq  = seq_q + 32'd1;
            end else begin
              state_d   = GAP;
              gap_ctr_d = gap_q;
              tvalid_d  = 1'b0;
              tdata_d   = '0;
              tkeep_d   = '0;
              tlast_d   = 1'b0;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop || stop_req_q) begin
          state_d = IDLE;
        end else if (gap_ctr_q == 8'd1) begin
          state_d = SEND;
          load    = 1'b1;
          ld_beat = 8'd0;
        end else begin
          gap_ctr_d = gap_ctr_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ld_last = last_beat_of(ld_len);
    if (load) begin
      beat_d   = ld_beat;
      tvalid_d = 1'b1;
      tdata_d  = beat_data(ld_beat, ld_seq, ld_len);
      tlast_d  = (ld_beat == ld_last);
      tkeep_d  = (ld_beat == ld_last) ? last_keep_of(ld_len) : 8'hFF;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      last_beat_q <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      gap_ctr_q   <= '0;
      beat_q      <= '0;
      seq_q       <= '0;
      sent_q      <= '0;
      stop_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      last_beat_q <= last_beat_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      gap_ctr_q   <= gap_ctr_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      sent_q      <= sent_d;
      stop_req_q  <= stop_req_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
    end
  end

  assign busy      = busy_q;
  assign sent_cnt  = sent_q;
  assign tx_tvalid = tvalid_q;
  assign tx_tdata  = tdata_q;
  assign tx_tkeep  = tkeep_q;
  assign tx_tlast  = tlast_q;
  assign tx_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: a byte-level frame model checks every accepted beat,
// backpressure stability and inter-frame gaps; directed runs pin the model with literals.
module tb_eth_frame_gen;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [10:0] frameLen;
  logic [15:0] frameCnt;
  logic [7:0]  gapIn;
  logic        busy;
  logic [31:0] sentCnt;
  logic        txReady;
  logic        txValid;
  logic [63:0] txData;
  logic [7:0]  txKeep;
  logic        txLast;
  logic        txUser;

  eth_frame_gen dut (
    .clk156    (clock),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .frame_len (frameLen),
    .frame_cnt (frameCnt),
    .gap       (gapIn),
    .busy      (busy),
    .sent_cnt  (sentCnt),
    .tx_tready (txReady),
    .tx_tvalid (txValid),
    .tx_tdata  (txData),
    .tx_tkeep  (txKeep),
    .tx_tlast  (txLast),
    .tx_tuser  (txUser)
  );

  int checks = 0;
  int errors = 0;

  // Model state: which frame/beat the sink should see next.
  bit          modelOn = 0;
  bit          randReady = 0;
  int          expLen = 60;
  int          expGap = 0;
  int          monFrame = 0;
  int          monBeat = 0;
  bit          inGap = 0;
  int          gapCount = 0;
  int          lastGap = -1;
  bit          prevStall = 0;
  logic [63:0] prevData;
  logic [7:0]  prevKeep;
  logic        prevLast;
  int          cycle = 0;
  int          lastTlastCycle = 0;
  logic [63:0] beat0Data [8];
  logic [63:0] beat1Data [8];
  logic [63:0] beat2Data [8];
  int          beatsSeen [8];
  logic [7:0]  lastKeep  [8];

  initial clock = 0;
  always #3 clock = ~clock;

  initial begin
    txReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      txReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input int i, input int unsigned seq);
    logic [111:0] hdr;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    if (i < 14)      return hdr[111-8*i -: 8];
    else if (i < 18) return 8'(seq >> (8*(17-i)));
    else             return 8'(i);
  endfunction

  function automatic int clampLen(input int l);
    return (l < 60) ? 60 : ((l > 1514) ? 1514 : l);
  endfunction

  always @(negedge clock) begin
    logic [63:0] eData;
    logic [7:0]  eKeep;
    logic        eLast;
    int          nBeats;
    cycle++;
    if (modelOn) begin
      if (prevStall) begin
        checkOutput("stall_valid", 64'(txValid), 64'd1);
        checkOutput("stall_data", txData, prevData);
        checkOutput("stall_keep", 64'(txKeep), 64'(prevKeep));
        checkOutput("stall_last", 64'(txLast), 64'(prevLast));
      end
      if (txValid && inGap) begin
        checkOutput("gap_len", 64'(gapCount), 64'(expGap));
        lastGap = gapCount;
        inGap = 0;
      end else if (!txValid && inGap) begin
        gapCount++;
      end
      if (!txValid && monBeat != 0) checkOutput("valid_drop", 64'(txValid), 64'd1);
      if (txValid && txReady) begin
        nBeats = (expLen + 7) / 8;
        for (int n = 0; n < 8; n++)
          eData[8*n +: 8] = (monBeat*8 + n < expLen) ? expByte(monBeat*8 + n, monFrame) : 8'h00;
        eLast = (monBeat == nBeats - 1);
        eKeep = !eLast ? 8'hFF : ((expLen % 8 == 0) ? 8'hFF : (8'hFF >> (8 - expLen % 8)));
        checkOutput("beat_data", txData, eData);
        checkOutput("beat_keep", 64'(txKeep), 64'(eKeep));
        checkOutput("beat_last", 64'(txLast), 64'(eLast));
        checkOutput("beat_user", 64'(txUser), 64'd0);
        if (monFrame < 8) begin
          if (monBeat == 0) beat0Data[monFrame] = txData;
          if (monBeat == 1) beat1Data[monFrame] = txData;
          if (monBeat == 2) beat2Data[monFrame] = txData;
        end
        if (txLast) begin
          if (monFrame < 8) begin
            beatsSeen[monFrame] = monBeat + 1;
            lastKeep[monFrame]  = txKeep;
          end
          monFrame++;
          monBeat = 0;
          inGap = 1;
          gapCount = 0;
          lastTlastCycle = cycle;
        end else begin
          monBeat++;
        end
      end
      prevStall = txValid && !txReady;
      prevData  = txData;
      prevKeep  = txKeep;
      prevLast  = txLast;
    end
  end

  task automatic applyStimulus(input int len, input int cnt, input int g);
    @(negedge clock);
    #1;
    frameLen  = 11'(len);
    frameCnt  = 16'(cnt);
    gapIn     = 8'(g);
    expLen    = clampLen(len);
    expGap    = g;
    monFrame  = 0;
    monBeat   = 0;
    inGap     = 0;
    gapCount  = 0;
    lastGap   = -1;
    prevStall = 0;
    for (int f = 0; f < 8; f++) beatsSeen[f] = 0;
    modelOn   = 1;
    start     = 1'b1;
    @(negedge clock);
    #1;
    start     = 1'b0;
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_valid", 64'(txValid), 64'd1);
    checkOutput("start_sent", 64'(sentCnt), 64'd0);
    frameLen  = 11'd0;
    frameCnt  = 16'd7;
    gapIn     = 8'd9;
  endtask

  task automatic waitIdle(input int maxCycles, input bit checkDelay);
    bit done = 0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      @(negedge clock);
      #1;
      if (!busy) done = 1;
    end
    checkOutput("idle_reached", 64'(done), 64'd1);
    if (done && checkDelay) checkOutput("busy_fall", 64'(cycle - lastTlastCycle), 64'd1);
    modelOn = 0;
  endtask

  task automatic waitBeat(input int frame, input int beat);
    bit hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clock);
      #1;
      if (monFrame == frame && monBeat == beat) hit = 1;
    end
    checkOutput("beat_reached", 64'(hit), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    frameLen = 11'd64;
    frameCnt = 16'd1;
    gapIn = 8'd0;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_valid", 64'(txValid), 64'd0);
    checkOutput("rst_data", txData, 64'd0);
    checkOutput("rst_keep", 64'(txKeep), 64'd0);
    checkOutput("rst_sent", 64'(sentCnt), 64'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;

    $display("[TB] single 64-byte frame");
    applyStimulus(64, 1, 0);
    waitIdle(100, 1);
    checkOutput("t1_beat0", beat0Data[0], 64'h0002_FFFF_FFFF_FFFF);
    checkOutput("t1_beat1", beat1Data[0], 64'h0000_B588_0100_0000);
    checkOutput("t1_beats", 64'(beatsSeen[0]), 64'd8);
    checkOutput("t1_keep", 64'(lastKeep[0]), 64'hFF);
    checkOutput("t1_sent", 64'(sentCnt), 64'd1);

    $display("[TB] length clamps and tail keep");
    applyStimulus(61, 1, 0);
    waitIdle(100, 1);
    checkOutput("len61_beats", 64'(beatsSeen[0]), 64'd8);
    checkOutput("len61_keep", 64'(lastKeep[0]), 64'h1F);
    applyStimulus(30, 1, 0);
    waitIdle(100, 1);
    checkOutput("len30_beats", 64'(beatsSeen[0]), 64'd8);
    checkOutput("len30_keep", 64'(lastKeep[0]), 64'h0F);
    applyStimulus(2000, 1, 0);
    waitIdle(400, 1);
    checkOutput("len2000_beats", 64'(beatsSeen[0]), 64'd190);
    checkOutput("len2000_keep", 64'(lastKeep[0]), 64'h03);

    $display("[TB] three frames with gap 4");
    applyStimulus(64, 3, 4);
    waitIdle(200, 1);
    checkOutput("t3_gap", 64'(lastGap), 64'd4);
    for (int f = 0; f < 3; f++) begin
      checkOutput("t3_b1_hi", 64'(beat1Data[f][63:48]), 64'd0);
      checkOutput("t3_b2_seq", 64'(beat2Data[f][15:0]), 64'({8'(f), 8'h00}));
    end
    checkOutput("t3_frames", 64'(monFrame), 64'd3);
    checkOutput("t3_sent", 64'(sentCnt), 64'd3);

    $display("[TB] random backpressure");
    randReady = 1;
    applyStimulus(100, 5, 1);
    waitIdle(3000, 1);
    randReady = 0;
    checkOutput("t4_frames", 64'(monFrame), 64'd5);
    checkOutput("t4_sent", 64'(sentCnt), 64'd5);

    $display("[TB] continuous run ended by stop");
    applyStimulus(64, 0, 2);
    waitBeat(1, 2);
    frameLen = 11'd200;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitBeat(2, 3);
    stop = 1'b1;
    waitIdle(200, 1);
    stop = 1'b0;
    checkOutput("t5_frames", 64'(monFrame), 64'd3);
    checkOutput("t5_last_beats", 64'(beatsSeen[2]), 64'd8);
    checkOutput("t5_sent", 64'(sentCnt), 64'd3);

    $display("[TB] reset mid-frame");
    applyStimulus(64, 2, 0);
    waitBeat(1, 4);
    modelOn = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_valid", 64'(txValid), 64'd0);
    checkOutput("mid_rst_last", 64'(txLast), 64'd0);
    checkOutput("mid_rst_data", txData, 64'd0);
    checkOutput("mid_rst_keep", 64'(txKeep), 64'd0);
    checkOutput("mid_rst_sent", 64'(sentCnt), 64'd0);
    checkOutput("mid_rst_user", 64'(txUser), 64'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    applyStimulus(64, 1, 0);
    waitIdle(100, 1);
    checkOutput("t6_beat1", beat1Data[0], 64'h0000_B588_0100_0000);
    checkOutput("t6_sent", 64'(sentCnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Synthesizable Ethernet test-frame transmitter that sources frames onto a 64-bit AXI-Stream master, the same beat format the PHY rx/tx ports of the simulation DUT carry. It sits on the stimulus side of the bench or board, driving a `phyN_rx_*` port. It emits a configurable number of fixed-length frames with header, sequence number and predictable payload, and fully honours `tready` backpressure. FCS is not generated; the MAC/PHY layer appends it.

## Interface
- `DST_MAC`, default 48'hFFFF_FFFF_FFFF: destination MAC, bytes 0-5, MSB first.
- `SRC_MAC`, default 48'h0200_0000_0001: source MAC, bytes 6-11, MSB first.
- `ETHERTYPE`, default 16'h88B5: bytes 12-13, MSB first.

Ports:
- `clk156`  in  1  156.25 MHz clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse that starts a run; sampled only in IDLE.
- `stop`  in  1  level request to end the run early.
- `frame_len`  in  11  frame length in bytes excluding FCS; latched on start.
- `frame_cnt`  in  16  frames per run, 0 = continuous; latched on start.
- `gap`  in  8  idle cycles between frames; latched on start.
- `busy`  out  1  high while a run is active.
- `sent_cnt`  out  32  frames fully accepted in the current run.
- `tx_tready`  in  1  sink ready.
- `tx_tvalid`  out  1  beat valid.
- `tx_tdata`  out  64  beat data; byte n of the beat is in [8n+7:8n].
- `tx_tkeep`  out  8  byte enables.
- `tx_tlast`  out  1  last beat of the frame.
- `tx_tuser`  out  1  error flag; always 0.

## Operation
- States: IDLE, SEND, GAP.
- IDLE -> SEND when `start`=1. On this edge the block latches its configuration, clears `sent_cnt`, sets seq=0 and beat index=0.
- Length clamp at latch: less than 60 becomes 60; greater than 1514 becomes 1514. beats = ceil(len/8).
- Frame bytes:
  - Bytes 0-11 are DST_MAC then SRC_MAC.
  - Bytes 12-13 are ETHERTYPE.
  - Bytes 14-17 are seq, 32-bit big-endian.
  - Each byte i ≥ 18 is i[7:0].
- `tkeep` = 8'hFF on every beat except the last. On the last beat, r = len mod 8: r=0 gives 8'hFF, otherwise (1<<r)-1. Bytes with tkeep=0 are driven 0.
- A beat transfers when `tvalid`&&`tready`. While `tvalid`=1 and `tready`=0, `tdata`/`tkeep`/`tlast` hold stable and `tvalid` must not drop.
- When the `tlast` beat transfers:
  - `sent_cnt` and seq increment.
  - If the run is complete (`sent_cnt` reaches `frame_cnt`, `frame_cnt`≠0) or `stop`=1: go to IDLE.
  - Else if `gap`=0: stay in SEND, and the next frame's beat 0 is valid on the following cycle.
  - Else: go to GAP.
- GAP: `tvalid`=0 for exactly `gap` cycles, then SEND. `stop`=1 in GAP goes to IDLE on the next edge.
- `stop` asserted in SEND does not truncate the frame: the current frame completes, then the block goes to IDLE.
- `start` is ignored while `busy`=1. `start` and `stop` asserted together in IDLE: the run starts, and after the first frame completes the block goes to IDLE.
- `busy` = (state ≠ IDLE).
- seq wraps from 2^32-1 to 0. `sent_cnt` wraps likewise.

## Timing
- Reset values (on `rst_n`=0, asynchronously):
  - State IDLE.
  - `busy`, `tvalid`, `tlast`, `tuser` = 0.
  - `tdata` = 0, `tkeep` = 0, `sent_cnt` = 0.
- Reset mid-frame truncates the frame immediately, with no `tlast`.
- All outputs are registered.
- `start` at edge k gives `busy`=1 and `tvalid`=1 with beat 0 after edge k.
- With `tready` held at 1, a frame occupies exactly `beats` consecutive cycles.
- Frame-to-frame spacing is `gap` cycles with `tvalid`=0 between the `tlast` transfer and the next beat 0.
- `sent_cnt` updates on the same edge that accepts `tlast`.
- `busy` falls on that edge when the run ends.

## Test plan
- len=64, cnt=1, gap=0, `tready`=1:
  - 8 beats.
  - beat0 `tdata`=64'h0002_FFFF_FFFF_FFFF.
  - beat1 `tdata`=64'h0000_B588_0100_0000.
  - beat7 `tkeep`=FF, `tlast`=1.
  - `sent_cnt`=1, and `busy` falls one cycle after the `tlast` transfer.
- len=61 -> 8 beats, last `tkeep`=8'h1F. len=30 -> clamped to 60, 8 beats, last `tkeep`=8'h0F. len=2000 -> 190 beats, last `tkeep`=8'h03.
- len=64, cnt=3, gap=4, `tready`=1:
  - exactly 4 `tvalid`-low cycles between frames.
  - beat1 lanes 6-7 are 00,00 in every frame.
  - beat2 lanes 0-1 carry seq 00,00 / 00,01 / 00,02 across the three frames.
  - final `sent_cnt`=3.
- Random `tready` (50%), cnt=5:
  - `tdata`/`tkeep`/`tlast` stable whenever `tvalid`&&!`tready`.
  - received byte stream identical to the `tready`=1 run.
- cnt=0 with `stop` raised mid-beat 3 of frame 2: frame 2 completes with `tlast`, then IDLE with `sent_cnt`=3 (frames 0,1,2). A `start` pulsed while `busy` has no effect.
- `rst_n` low during beat 4: all outputs 0 immediately; after release, a new `start` gives seq=0 and `sent_cnt`=0.
